// File: rtl/dcache_axi_wb.sv
// Write-back engine: takes one dirty line from the dcache write FIFO and
// drains it as a single AXI4 INCR burst, reporting free once B is consumed.
//
// state | meaning
// IDLE  | no burst in flight, free_o high, waiting for a line
// ADDR  | line latched, presenting AW until awready_i
// DATA  | streaming beats on W, cnt_q selects the current beat
// RESP  | all beats sent, waiting for the B response
module dcache_axi_wb #(
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned AXI_ID     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fifo_wen_i,
   input  logic [LINE_WIDTH-1:0]     fifo_wdata_i,
   input  logic [31:0]               fifo_awaddr_i,
   output logic                      free_o,
   output logic                      busy_o,
   output logic                      wr_err_o,
   output logic [ID_WIDTH-1:0]       awid_o,
   output logic [31:0]               awaddr_o,
   output logic [7:0]                awlen_o,
   output logic [2:0]                awsize_o,
   output logic [1:0]                awburst_o,
   output logic                      awvalid_o,
   input  logic                      awready_i,
   output logic [DATA_WIDTH-1:0]     wdata_o,
   output logic [DATA_WIDTH/8-1:0]   wstrb_o,
   output logic                      wlast_o,
   output logic                      wvalid_o,
   input  logic                      wready_i,
   input  logic [1:0]                bresp_i,
   input  logic                      bvalid_i,
   output logic                      bready_o
);

   localparam int unsigned BEATS    = LINE_WIDTH / DATA_WIDTH;
   localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned SIZE     = $clog2(DATA_WIDTH / 8);
   localparam logic [31:0] OFF_MASK = 32'(LINE_WIDTH / 8 - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0]   line_q, line_d;
   logic [31:0]             addr_q, addr_d;
   logic                    err_q, err_d;
   logic                    last_beat;

   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      addr_d  = addr_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (fifo_wen_i) begin
               line_d  = fifo_wdata_i;
               addr_d  = fifo_awaddr_i & ~OFF_MASK;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (awready_i) state_d = DATA;
         end
         DATA: begin
            if (wready_i) begin
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = RESP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         RESP: begin
            if (bvalid_i) begin
               err_d   = err_q | (bresp_i != 2'b00);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // free_o is gated by rst so the FIFO never pops while the engine is held in reset
   always_comb begin
      free_o    = (state_q == IDLE) && rst;
      busy_o    = (state_q != IDLE) && rst;
      awvalid_o = (state_q == ADDR);
      wvalid_o  = (state_q == DATA);
      wlast_o   = (state_q == DATA) && last_beat;
      bready_o  = (state_q == RESP);
      wr_err_o  = err_q;
      awid_o    = ID_WIDTH'(AXI_ID);
      awaddr_o  = addr_q;
      awlen_o   = 8'(BEATS - 1);
      awsize_o  = 3'(SIZE);
      awburst_o = 2'b01;
      wdata_o   = line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
      wstrb_o   = '1;
   end

endmodule

// File: tb/tb_dcache_axi_wb.sv
// Directed bench for dcache_axi_wb: reset, single line, backpressure,
// back-to-back lines, error response and reset in the middle of a burst.
module tb_dcache_axi_wb;

   logic          clk;
   logic          rst;
   logic          fifo_wen_i;
   logic [127:0]  fifo_wdata_i;
   logic [31:0]   fifo_awaddr_i;
   logic          free_o, busy_o, wr_err_o;
   logic [3:0]    awid_o;
   logic [31:0]   awaddr_o;
   logic [7:0]    awlen_o;
   logic [2:0]    awsize_o;
   logic [1:0]    awburst_o;
   logic          awvalid_o, awready_i;
   logic [31:0]   wdata_o;
   logic [3:0]    wstrb_o;
   logic          wlast_o, wvalid_o, wready_i;
   logic [1:0]    bresp_i;
   logic          bvalid_i, bready_o;

   int tests_run = 0;
   int tests_failed = 0;

   dcache_axi_wb dut (
      .clk(clk), .rst(rst),
      .fifo_wen_i(fifo_wen_i), .fifo_wdata_i(fifo_wdata_i), .fifo_awaddr_i(fifo_awaddr_i),
      .free_o(free_o), .busy_o(busy_o), .wr_err_o(wr_err_o),
      .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
      .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
      .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one burst starting in a cycle where the engine should be free.
   // After acceptance the FIFO inputs are either the next line (hold_wen) or garbage.
   task automatic burst(input logic [31:0] addr, input logic [127:0] line,
                        input int aw_stall, input bit w_toggle,
                        input logic [1:0] resp, input bit exp_err,
                        input bit hold_wen, input logic [31:0] nxt_addr,
                        input logic [127:0] nxt_line);
      int n;
      int beat;
      int cyc;
      logic [31:0] exp_beat;
      n = 0;
      chk("free_before", free_o, 1'b1);
      fifo_wen_i = 1'b1; fifo_awaddr_i = addr; fifo_wdata_i = line;
      awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
      step(); n++;
      fifo_wen_i    = hold_wen;
      fifo_awaddr_i = hold_wen ? nxt_addr : ~addr;
      fifo_wdata_i  = hold_wen ? nxt_line : ~line;
      for (int k = 0; k <= aw_stall; k++) begin
         chk("awvalid", awvalid_o, 1'b1);
         chk("awaddr", awaddr_o, {addr[31:4], 4'h0});
         chk("wvalid_in_addr", wvalid_o, 1'b0);
         chk("free_in_addr", free_o, 1'b0);
         awready_i = (k == aw_stall);
         step(); n++;
      end
      awready_i = 1'b0;
      beat = 0;
      cyc = 0;
      while (beat < 4 && cyc < 20) begin
         exp_beat = line[beat*32 +: 32];
         chk("wvalid", wvalid_o, 1'b1);
         chk("wdata", wdata_o, exp_beat);
         chk("wlast", wlast_o, (beat == 3));
         chk("awvalid_in_data", awvalid_o, 1'b0);
         wready_i = w_toggle ? (cyc % 2 == 0) : 1'b1;
         if (wready_i) beat++;
         step(); n++;
         cyc++;
      end
      wready_i = 1'b0;
      chk("w_handshakes", beat, 4);
      chk("wvalid_after", wvalid_o, 1'b0);
      chk("bready", bready_o, 1'b1);
      bvalid_i = 1'b1; bresp_i = resp;
      step(); n++;
      bvalid_i = 1'b0; bresp_i = 2'b00;
      chk("free_after", free_o, 1'b1);
      chk("awvalid_at_free", awvalid_o, 1'b0);
      chk("bready_after", bready_o, 1'b0);
      chk("wr_err", wr_err_o, exp_err);
      if (aw_stall == 0 && !w_toggle) chk("latency", n, 7);
   endtask

   initial begin
      rst = 1'b0;
      fifo_wen_i = 1'b0; fifo_wdata_i = '0; fifo_awaddr_i = '0;
      awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0;

      // 1: reset and release
      #12;
      chk("rst_free", free_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      step();
      rst = 1'b1;
      #1;
      chk("idle_free", free_o, 1'b1);
      chk("idle_busy", busy_o, 1'b0);
      chk("idle_awvalid", awvalid_o, 1'b0);
      chk("idle_wvalid", wvalid_o, 1'b0);
      chk("idle_bready", bready_o, 1'b0);
      chk("idle_wr_err", wr_err_o, 1'b0);
      step();

      // 2: single line, no stalls
      fifo_wen_i = 1'b1; fifo_awaddr_i = 32'h1C00_0034;
      fifo_wdata_i = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      step();
      fifo_wen_i = 1'b0;
      chk("t2_awaddr", awaddr_o, 32'h1C00_0030);
      chk("t2_awlen", awlen_o, 8'd3);
      chk("t2_awsize", awsize_o, 3'd2);
      chk("t2_awburst", awburst_o, 2'b01);
      chk("t2_awid", awid_o, 4'd0);
      chk("t2_wstrb", wstrb_o, 4'hF);
      chk("t2_busy", busy_o, 1'b1);
      rst = 1'b0; #1; rst = 1'b1;
      step();
      burst(32'h1C00_0034, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
            0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 128'h0);

      // 3: backpressure on AW and W
      burst(32'h0000_1008, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001,
            3, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 128'h0);

      // 4+5: back-to-back with fifo_wen_i held, SLVERR on first burst
      burst(32'h2000_0040, 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0BAD_F00D,
            0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h2000_0050,
            128'h5555_5555_6666_6666_7777_7777_8888_8888);
      burst(32'h2000_0050, 128'h5555_5555_6666_6666_7777_7777_8888_8888,
            1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 128'h0);
      step();
      chk("t5_wr_err_sticky", wr_err_o, 1'b1);

      // 6: reset during beat 2
      fifo_wen_i = 1'b1; fifo_awaddr_i = 32'h3000_0000;
      fifo_wdata_i = 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0;
      step();
      fifo_wen_i = 1'b0; awready_i = 1'b1;
      step();
      awready_i = 1'b0; wready_i = 1'b1;
      step();
      step();
      wready_i = 1'b0;
      chk("t6_beat2", wdata_o, 32'hA2A2_A2A2);
      rst = 1'b0;
      #1;
      chk("t6_wvalid", wvalid_o, 1'b0);
      chk("t6_awvalid", awvalid_o, 1'b0);
      chk("t6_bready", bready_o, 1'b0);
      chk("t6_wlast", wlast_o, 1'b0);
      chk("t6_free", free_o, 1'b0);
      chk("t6_busy", busy_o, 1'b0);
      chk("t6_wr_err", wr_err_o, 1'b0);
      step();
      rst = 1'b1;
      #1;
      chk("t6_free_release", free_o, 1'b1);
      step();
      burst(32'h3000_0100, 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0,
            0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
